// File: rtl/sub16_serial_pkg.sv
// Shared types and constants for the serial subtractor and its sibling adder.
// The flag bit positions match the adder's flag bus.
package sub16_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  localparam int SIGN         = 0;
  localparam int ZERO         = 1;
  localparam int CARRY_BORROW = 2;
  localparam int PARITY       = 3;
  localparam int OVF          = 4;
  localparam int NFLAGS       = 5;

endpackage

// File: rtl/sub16_serial_if.sv
// Operand/result handshake bundle for sub16_serial.
interface sub16_serial_if
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             Sign;
  logic             Zero;
  logic             Borrow;
  logic             Parity;
  logic             Overflow;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, Z, Sign, Zero, Borrow, Parity, Overflow
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, Z, Sign, Zero, Borrow, Parity, Overflow
  );
endinterface

// File: rtl/sub16_serial_sub4.sv
// Combinational slice subtractor with borrow in/out; counterpart of the 4-bit adder block.
module sub4
  import sub16_serial_pkg::*;
#(
  parameter int W = DEF_SLICE
) (
  output logic [W-1:0] d,
  output logic         bout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin
);
  logic [W:0] t;

  // One extra bit: the wrapped MSB is exactly the borrow out.
  assign t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = t[W-1:0];
  assign bout = t[W];
endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle subtractor: Z = X - Y one slice per clock, LSB slice first,
// with adder-compatible status flags registered when the last slice completes.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input logic           clk,
  input logic           rst,
  sub16_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  xr, yr, zr, zfin;
  logic              br, bo;
  logic [SLICE-1:0]  xs, ys, ds;
  logic [NFLAGS-1:0] flags;
  logic              ovalid;
  logic              accept, run, last, finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run       = 1'b0;
    last      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (idx == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xs = xr[idx*SLICE +: SLICE];
  assign ys = yr[idx*SLICE +: SLICE];

  sub4 #(.W(SLICE)) u_sub4 (
    .d    (ds),
    .bout (bo),
    .a    (xs),
    .b    (ys),
    .bin  (br)
  );

  // Result as it will stand after this cycle's slice is written; flags use it directly.
  always_comb begin
    zfin = zr;
    zfin[idx*SLICE +: SLICE] = ds;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      br     <= 1'b0;
      idx    <= '0;
      flags  <= '0;
      ovalid <= 1'b0;
    end else begin
      if (accept) begin
        xr  <= bus.X;
        yr  <= bus.Y;
        br  <= 1'b0;
        idx <= '0;
      end
      if (run) begin
        zr <= zfin;
        br <= bo;
        if (!last) idx <= idx + 1'b1;
      end
      if (last) begin
        flags[SIGN]         <= zfin[WIDTH-1];
        flags[ZERO]         <= (zfin == '0);
        flags[CARRY_BORROW] <= bo;
        flags[PARITY]       <= ~^zfin;
        flags[OVF]          <= (xr[WIDTH-1] & ~yr[WIDTH-1] & ~zfin[WIDTH-1]) |
                               (~xr[WIDTH-1] & yr[WIDTH-1] & zfin[WIDTH-1]);
        ovalid              <= 1'b1;
      end
      if (finish) ovalid <= 1'b0;
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = ovalid;
  assign bus.Z         = zr;
  assign bus.Sign      = flags[SIGN];
  assign bus.Zero      = flags[ZERO];
  assign bus.Borrow    = flags[CARRY_BORROW];
  assign bus.Parity    = flags[PARITY];
  assign bus.Overflow  = flags[OVF];
endmodule

// File: tb/tb_sub16_serial.sv
// Bench for sub16_serial: directed corner cases, backpressure, mid-run reset,
// then randomized operations against an arithmetic reference model.
module tb_sub16_serial;
  import sub16_serial_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sub16_serial_if #(.WIDTH(16)) bus ();

  sub16_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.Sign, bus.Zero, bus.Borrow, bus.Parity, bus.Overflow};
  endfunction

  // Reference: {Sign, Zero, Borrow, Parity, Overflow} from plain integer arithmetic.
  function automatic logic [4:0] model_flags(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] z;
    int          sd;
    logic        ovf;
    z   = x - y;
    sd  = int'($signed(x)) - int'($signed(y));
    ovf = (sd > 32767) || (sd < -32768);
    return {z[15], z == 16'h0, x < y, ($countones(z) % 2) == 0, ovf};
  endfunction

  // noise: 0 = in_valid low while busy, 1 = in_valid high with X=FFFF/Y=0001, 2 = random junk
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input int hold, input int noise, input bit use_exp,
                        input logic [15:0] ez, input logic [4:0] ef);
    int          n;
    logic [15:0] z_exp;
    logic [4:0]  f_exp;
    z_exp = use_exp ? ez : 16'(x - y);
    f_exp = use_exp ? ef : model_flags(x, y);

    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    if (n >= 50) begin
      chk({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.X = x;
    bus.Y = y;
    step();

    n = 0;
    while (!bus.out_valid && n < 20) begin
      case (noise)
        1: begin bus.in_valid = 1'b1; bus.X = 16'hFFFF; bus.Y = 16'h0001; end
        2: begin bus.in_valid = 1'($urandom_range(0, 1)); bus.X = 16'($urandom); bus.Y = 16'($urandom); end
        default: bus.in_valid = 1'b0;
      endcase
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    chk({tag, "_z"}, 32'(bus.Z), 32'(z_exp));
    chk({tag, "_flags"}, 32'(flags_now()), 32'(f_exp));

    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_z"}, 32'(bus.Z), 32'(z_exp));
      chk({tag, "_hold_flags"}, 32'(flags_now()), 32'(f_exp));
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end

    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_z"}, 32'(bus.Z), 32'(z_exp));
    chk({tag, "_idle_flags"}, 32'(flags_now()), 32'(f_exp));
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [15:0] rx, ry;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z", 32'(bus.Z), 32'd0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    run_op("c1", 16'h1234, 16'h0234, 0, 0, 1'b1, 16'h1000, 5'b00000);
    run_op("c2", 16'h0000, 16'h0001, 1, 2, 1'b1, 16'hFFFF, 5'b10110);
    run_op("c3", 16'h8000, 16'h0001, 0, 0, 1'b1, 16'h7FFF, 5'b00001);
    run_op("c4", 16'h5A5A, 16'h5A5A, 2, 0, 1'b1, 16'h0000, 5'b01010);

    // Backpressure with a competing request held high throughout.
    run_op("c5a", 16'h1234, 16'h0234, 10, 1, 1'b1, 16'h1000, 5'b00000);
    run_op("c5b", 16'hFFFF, 16'h0001, 0, 0, 1'b1, 16'hFFFE, 5'b10000);

    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      ry = (i % 6 == 0) ? rx : 16'($urandom);
      run_op("rnd", rx, ry, $urandom_range(0, 3), 2, 1'b0, 16'h0, 5'h0);
    end
    bus.in_valid = 1'b0;

    // Reset with the slice index at 2.
    run_op("pre6", 16'hFFFF, 16'h0000, 0, 0, 1'b1, 16'hFFFF, 5'b10010);
    bus.in_valid = 1'b1;
    bus.X = 16'h1234;
    bus.Y = 16'h0234;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("c6_valid", 32'(bus.out_valid), 32'd0);
    chk("c6_z", 32'(bus.Z), 32'd0);
    chk("c6_flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;
    #1;
    chk("c6_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("c6_no_result", 32'(seen), 32'd0);
    run_op("c6_after", 16'h0F0F, 16'h1111, 0, 0, 1'b0, 16'h0, 5'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
